// File: rtl/depacketizer.sv
// depacketizer
// Parses Ethernet/IPv4/UDP frames from a byte-wide MAC receive port. It accepts
// only frames addressed to local_mac / local_ip / local_port that have the
// fixed sample-stream layout. For each accepted frame it streams the 366 I/Q
// samples to a sample sink and reports the frame's 64-bit sequence number.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   rx_clk            receive clock handed back to the MAC (driven from clk)
//   rx_data           receive byte
//   rx_dval           rx_data is valid this cycle
//   rx_sop            start of frame, qualified by rx_dval
//   rx_eop            end of frame, qualified by rx_dval
//   rx_err            error on this byte, qualified by rx_dval
//   rx_rdy            MAC may present data (high whenever out of reset)
//   wr_en             one-cycle write strobe to the sample sink
//   wr_data           written sample {I[15:0], Q[15:0]}
//   wr_full           sink cannot accept a write
//   seq_num           sequence value of the last accepted frame
//   seq_valid         one-cycle pulse per accepted frame
//   seq_gap           pulses with seq_valid when the sequence did not advance by one
//   frames_ok         saturating count of accepted frames
//   frames_drop       saturating count of dropped frames
//   samples_ovf       saturating count of samples lost to wr_full
module depacketizer #(
    parameter logic [47:0] local_mac  = 48'h02_12_34_56_78_90,
    parameter logic [31:0] local_ip   = {8'd192, 8'd168, 8'd2, 8'd1},
    parameter logic [15:0] local_port = 16'd32179
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rx_clk,
    input  logic [7:0]  rx_data,
    input  logic        rx_dval,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        rx_err,
    output logic        rx_rdy,
    output logic        wr_en,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    output logic [63:0] seq_num,
    output logic        seq_valid,
    output logic        seq_gap,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_drop,
    output logic [15:0] samples_ovf
);

    localparam logic [10:0] HDR_LAST     = 11'd49;
    localparam logic [10:0] PAYLOAD_FIRST = 11'd50;
    localparam logic [10:0] LAST_BYTE    = 11'd1513;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DISCARD} state_t;

    state_t      state;
    state_t      next_state;

    // Index the next in-frame byte will carry; only valid bytes advance it.
    logic [10:0] byte_idx;
    logic [10:0] cur_b;
    logic [2:0]  seq_lane;

    logic        frame_byte;
    logic        abort_prev;
    logic        hdr_ok;
    logic        byte_fail;
    logic        accept;
    logic        sample_done;

    logic [15:0] i_sample;
    logic [7:0]  q_lo;
    logic [63:0] seq_cap;
    logic        have_prev;

    assign rx_clk = clk;
    assign rx_rdy = ~rst;

    // Sequence bytes b42..b49 land little-endian; b42 has low bits 3'd2.
    assign seq_lane = cur_b[2:0] - 3'd2;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cur_b       = rx_sop ? 11'd0 : byte_idx;
        frame_byte  = 1'b0;
        abort_prev  = 1'b0;
        hdr_ok      = 1'b1;
        byte_fail   = 1'b0;
        accept      = 1'b0;
        sample_done = 1'b0;

        // Only the fixed header fields are checked; everything else is don't-care.
        case (cur_b)
            11'd0:   hdr_ok = (rx_data == local_mac[47:40]);
            11'd1:   hdr_ok = (rx_data == local_mac[39:32]);
            11'd2:   hdr_ok = (rx_data == local_mac[31:24]);
            11'd3:   hdr_ok = (rx_data == local_mac[23:16]);
            11'd4:   hdr_ok = (rx_data == local_mac[15:8]);
            11'd5:   hdr_ok = (rx_data == local_mac[7:0]);
            11'd12:  hdr_ok = (rx_data == 8'h08);
            11'd13:  hdr_ok = (rx_data == 8'h00);
            11'd14:  hdr_ok = (rx_data == 8'h45);
            11'd16:  hdr_ok = (rx_data == 8'h05);
            11'd17:  hdr_ok = (rx_data == 8'hDC);
            11'd23:  hdr_ok = (rx_data == 8'h11);
            11'd30:  hdr_ok = (rx_data == local_ip[31:24]);
            11'd31:  hdr_ok = (rx_data == local_ip[23:16]);
            11'd32:  hdr_ok = (rx_data == local_ip[15:8]);
            11'd33:  hdr_ok = (rx_data == local_ip[7:0]);
            11'd36:  hdr_ok = (rx_data == local_port[15:8]);
            11'd37:  hdr_ok = (rx_data == local_port[7:0]);
            11'd38:  hdr_ok = (rx_data == 8'h05);
            11'd39:  hdr_ok = (rx_data == 8'hC8);
            default: hdr_ok = 1'b1;
        endcase

        if (rx_dval) begin
            // A start byte always restarts parsing; a frame still in HDR or
            // PAYLOAD has not been counted yet, so it is dropped here.
            if (rx_sop) begin
                frame_byte = 1'b1;
                abort_prev = (state == HDR) || (state == PAYLOAD);
            end else if ((state == HDR) || (state == PAYLOAD)) begin
                frame_byte = 1'b1;
            end else if ((state == DISCARD) && rx_eop) begin
                next_state = IDLE;
            end

            if (frame_byte) begin
                // End of frame must coincide exactly with the last byte.
                byte_fail = rx_err | ~hdr_ok | (rx_eop != (cur_b == LAST_BYTE));
                if (byte_fail) begin
                    next_state = rx_eop ? IDLE : DISCARD;
                end else if (cur_b == LAST_BYTE) begin
                    next_state = IDLE;
                    accept     = 1'b1;
                end else if (cur_b < HDR_LAST) begin
                    next_state = HDR;
                end else begin
                    next_state = PAYLOAD;
                end
                sample_done = ~byte_fail && (cur_b >= PAYLOAD_FIRST) && (cur_b[1:0] == 2'b01);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx    <= 11'd0;
            i_sample    <= 16'd0;
            q_lo        <= 8'd0;
            seq_cap     <= 64'd0;
            have_prev   <= 1'b0;
            wr_en       <= 1'b0;
            wr_data     <= 32'd0;
            seq_num     <= 64'd0;
            seq_valid   <= 1'b0;
            seq_gap     <= 1'b0;
            frames_ok   <= 16'd0;
            frames_drop <= 16'd0;
            samples_ovf <= 16'd0;
        end else begin
            wr_en     <= 1'b0;
            seq_valid <= 1'b0;
            seq_gap   <= 1'b0;

            if (frame_byte) begin
                byte_idx <= cur_b + 11'd1;
            end

            if (frame_byte && (cur_b >= 11'd42) && (cur_b <= HDR_LAST)) begin
                seq_cap[{seq_lane, 3'b000} +: 8] <= rx_data;
            end

            // Payload bytes per sample arrive as I lo, I hi, Q lo, Q hi.
            if (frame_byte && (cur_b >= PAYLOAD_FIRST)) begin
                case (cur_b[1:0])
                    2'b10:   i_sample[7:0]  <= rx_data;
                    2'b11:   i_sample[15:8] <= rx_data;
                    2'b00:   q_lo           <= rx_data;
                    default: ;
                endcase
            end

            if (sample_done) begin
                if (!wr_full) begin
                    wr_en   <= 1'b1;
                    wr_data <= {i_sample, rx_data, q_lo};
                end else begin
                    samples_ovf <= sat_add(samples_ovf, 2'd1);
                end
            end

            if (accept) begin
                seq_num   <= seq_cap;
                seq_valid <= 1'b1;
                seq_gap   <= have_prev && (seq_cap != seq_num + 64'd1);
                have_prev <= 1'b1;
                frames_ok <= sat_add(frames_ok, 2'd1);
            end

            // A restart byte can drop the old frame and fail the new one at once.
            frames_drop <= sat_add(frames_drop, {1'b0, abort_prev} + {1'b0, byte_fail});
        end
    end

endmodule

// File: tb/tb_depacketizer.sv
// Testbench for depacketizer: table of frame scenarios applied in a loop, plus
// hand-written sequences for mid-frame restart and mid-frame reset. Expected
// samples are queued as payload is driven and compared as writes appear.
module tb_depacketizer;

    localparam logic [47:0] MAC  = 48'h02_12_34_56_78_90;
    localparam logic [31:0] IP   = {8'd192, 8'd168, 8'd2, 8'd1};
    localparam logic [15:0] PORT = 16'd32179;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_clk;
    logic [7:0]  rx_data;
    logic        rx_dval;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_err;
    logic        rx_rdy;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_full;
    logic [63:0] seq_num;
    logic        seq_valid;
    logic        seq_gap;
    logic [15:0] frames_ok;
    logic [15:0] frames_drop;
    logic [15:0] samples_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int n_sv     = 0;
    int n_gap    = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [63:0] seq;
        int          corrupt_b;
        int          err_b;
        int          full_n;
        int          exp_writes;
        int          exp_sv;
        int          exp_gap;
        int          exp_ok;
        int          exp_drop;
        int          exp_ovf;
        logic [63:0] exp_seq;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    depacketizer dut (
        .clk         (clk),
        .rst         (rst),
        .rx_clk      (rx_clk),
        .rx_data     (rx_data),
        .rx_dval     (rx_dval),
        .rx_sop      (rx_sop),
        .rx_eop      (rx_eop),
        .rx_err      (rx_err),
        .rx_rdy      (rx_rdy),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .seq_num     (seq_num),
        .seq_valid   (seq_valid),
        .seq_gap     (seq_gap),
        .frames_ok   (frames_ok),
        .frames_drop (frames_drop),
        .samples_ovf (samples_ovf)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write and pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got %08h, expected no write", wr_data);
            end else begin
                checkOutput("wr_data", {32'd0, wr_data}, {32'd0, exp_q.pop_front()});
            end
        end
        if (seq_valid === 1'b1) n_sv++;
        if (seq_gap === 1'b1) n_gap++;
    end

    task automatic applyStimulus(input logic [7:0] d, input logic sop, input logic eop,
                                 input logic err, input logic full);
        @(negedge clk);
        rx_data = d;
        rx_dval = 1'b1;
        rx_sop  = sop;
        rx_eop  = eop;
        rx_err  = err;
        wr_full = full;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_dval = 1'b0;
            rx_sop  = 1'b0;
            rx_eop  = 1'b0;
            rx_err  = 1'b0;
            wr_full = 1'b0;
            rx_data = 8'h00;
        end
    endtask

    function automatic logic [7:0] frame_data(input int b, input logic [63:0] seq);
        logic [15:0] kk;
        if (b < 6) return MAC[47 - 8*b -: 8];
        if (b < 12) return 8'hA0 + 8'(b);
        if (b >= 30 && b < 34) return IP[31 - 8*(b-30) -: 8];
        if (b >= 42 && b < 50) return seq[8*(b-42) +: 8];
        if (b >= 50) begin
            kk = 16'((b - 50) / 4);
            case ((b - 50) % 4)
                0:       return kk[7:0];
                1:       return kk[15:8];
                2:       return ~kk[7:0];
                default: return ~kk[15:8];
            endcase
        end
        case (b)
            12:      return 8'h08;
            13:      return 8'h00;
            14:      return 8'h45;
            16:      return 8'h05;
            17:      return 8'hDC;
            23:      return 8'h11;
            36:      return PORT[15:8];
            37:      return PORT[7:0];
            38:      return 8'h05;
            39:      return 8'hC8;
            default: return 8'h5A;
        endcase
    endfunction

    // Drives bytes 0..stop_b-1 of a frame and queues the samples that must be written.
    task automatic send_frame(input logic [63:0] seq, input int corrupt_b, input int err_b,
                              input int full_n, input int stop_b);
        logic       alive;
        logic [7:0] d;
        logic       full;
        logic [15:0] kk;
        alive = 1'b1;
        for (int b = 0; b < stop_b; b++) begin
            d = frame_data(b, seq);
            if (b == corrupt_b) d = d ^ 8'hFF;
            if (b == corrupt_b || b == err_b) alive = 1'b0;
            full = (b >= 50) && (((b - 50) / 4) < full_n);
            kk = 16'((b - 50) / 4);
            if (alive && b >= 50 && ((b - 50) % 4) == 3 && !full) exp_q.push_back({kk, ~kk});
            applyStimulus(d, b == 0, b == 1513, b == err_b, full);
        end
        idle_cycles(1);
    endtask

    task automatic clear_counts();
        n_writes = 0;
        n_sv     = 0;
        n_gap    = 0;
    endtask

    task automatic check_stats(input int writes, input int sv, input int gap, input int ok,
                               input int drop, input int ovf, input logic [63:0] sq);
        checkOutput("writes",      64'(writes), 64'(n_writes));
        checkOutput("queue_left",  64'(exp_q.size()), 64'd0);
        checkOutput("seq_valid_n", 64'(n_sv), 64'(sv));
        checkOutput("seq_gap_n",   64'(n_gap), 64'(gap));
        checkOutput("frames_ok",   {48'd0, frames_ok}, 64'(ok));
        checkOutput("frames_drop", {48'd0, frames_drop}, 64'(drop));
        checkOutput("samples_ovf", {48'd0, samples_ovf}, 64'(ovf));
        checkOutput("seq_num",     seq_num, sq);
    endtask

    task automatic check_reset_values();
        checkOutput("rst_rx_rdy",      {63'd0, rx_rdy}, 64'd0);
        checkOutput("rst_wr_en",       {63'd0, wr_en}, 64'd0);
        checkOutput("rst_wr_data",     {32'd0, wr_data}, 64'd0);
        checkOutput("rst_seq_num",     seq_num, 64'd0);
        checkOutput("rst_seq_valid",   {63'd0, seq_valid}, 64'd0);
        checkOutput("rst_seq_gap",     {63'd0, seq_gap}, 64'd0);
        checkOutput("rst_frames_ok",   {48'd0, frames_ok}, 64'd0);
        checkOutput("rst_frames_drop", {48'd0, frames_drop}, 64'd0);
        checkOutput("rst_samples_ovf", {48'd0, samples_ovf}, 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_dval = 1'b0;
        rx_sop  = 1'b0;
        rx_eop  = 1'b0;
        rx_err  = 1'b0;
        wr_full = 1'b0;

        //               seq                     corr err   full wr   sv gap ok drop ovf seq_num
        vecs[0] = '{64'd5,                  -1,  -1,  0,  366, 1, 0,  1, 0,   0,  64'd5};
        vecs[1] = '{64'd7,                  -1,  -1,  0,  366, 1, 1,  2, 0,   0,  64'd7};
        vecs[2] = '{64'd8,                  -1,  -1,  0,  366, 1, 0,  3, 0,   0,  64'd8};
        vecs[3] = '{64'd9,                  37,  -1,  0,  0,   0, 0,  3, 1,   0,  64'd8};
        vecs[4] = '{64'd9,                  -1,  -1,  0,  366, 1, 0,  4, 1,   0,  64'd9};
        vecs[5] = '{64'd10,                 -1,  800, 0,  187, 0, 0,  4, 2,   0,  64'd9};
        vecs[6] = '{64'd10,                 -1,  -1,  10, 356, 1, 0,  5, 2,   10, 64'd10};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, -1, -1,  0,  366, 1, 1,  6, 2,   10, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8] = '{64'd0,                  -1,  -1,  0,  366, 1, 0,  7, 2,   10, 64'd0};

        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rx_rdy_run", {63'd0, rx_rdy}, 64'd1);

        for (int i = 0; i < 9; i++) begin
            clear_counts();
            send_frame(vecs[i].seq, vecs[i].corrupt_b, vecs[i].err_b, vecs[i].full_n, 1514);
            idle_cycles(3);
            $display("[TB] frame row %0d done", i);
            check_stats(vecs[i].exp_writes, vecs[i].exp_sv, vecs[i].exp_gap, vecs[i].exp_ok,
                        vecs[i].exp_drop, vecs[i].exp_ovf, vecs[i].exp_seq);
        end

        // Start-of-frame at b300 abandons the current frame and restarts parsing.
        clear_counts();
        send_frame(64'd1, -1, -1, 0, 300);
        send_frame(64'd1, -1, -1, 0, 1514);
        idle_cycles(3);
        check_stats(62 + 366, 1, 0, 8, 3, 10, 64'd1);

        // Reset at b100 abandons the frame and clears all history.
        clear_counts();
        send_frame(64'd50, -1, -1, 0, 100);
        idle_cycles(2);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        checkOutput("pre_reset_writes", 64'(n_writes), 64'd12);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(8'(i), 1'b0, i == 10, 1'b0, 1'b0);
        @(negedge clk);
        rx_dval = 1'b0;
        rx_sop  = 1'b1;
        rx_data = MAC[47:40];
        idle_cycles(3);
        checkOutput("post_reset_ok",   {48'd0, frames_ok}, 64'd0);
        checkOutput("post_reset_drop", {48'd0, frames_drop}, 64'd0);
        checkOutput("post_reset_writes", 64'(n_writes), 64'd12);

        clear_counts();
        send_frame(64'd100, -1, -1, 0, 1514);
        idle_cycles(3);
        check_stats(366, 1, 0, 1, 0, 0, 64'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
